// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// - op encodings mirror the decoder's muxfour field
// - FSM state encoding for muldiv_sequencer
// - ITER_LAST: final iteration index of the CALC phase
package muldiv_pkg;

  localparam logic [1:0] MD_NONE  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic [4:0] ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_divstep.sv
// One combinational restoring-division step.
// Ports:
//   part_rem  in   WIDTH+1  shifted partial remainder {rem, next dividend bit}
//   divisor   in   WIDTH    divisor magnitude
//   new_rem   out  WIDTH    remainder after the trial subtract (restored if negative)
//   q_bit     out  1        quotient bit produced by this step
module md_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // part_rem < 2*divisor, so the MSB of the WIDTH+1 difference is a clean borrow flag.
  assign diff    = part_rem - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign new_rem = q_bit ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO controller: MULTU (shift-add), DIV and DIVU (restoring, radix-2).
// IDLE -> CALC (ITER steps) -> FIN (one-cycle write of HI and LO) -> IDLE.
// Optional: define MULDIV_EARLY_OUT_EN to skip CALC when opb==0 (any op) or opa==0 (MULTU).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op         issue strobe and operation (sampled only in IDLE)
//   opa, opb          rs / rt operands
//   cancel            flush; aborts in-flight op, suppresses the write
//   busy, stall       in-flight flag; pipeline hold (includes the issue cycle)
//   done, hi_we, lo_we  one-cycle completion / write enables
//   hi_out, lo_out    HI (product high / remainder), LO (product low / quotient)
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  import muldiv_pkg::*;

  localparam int unsigned CntW = $clog2(ITER);

  md_state_e          state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               issue;
  logic [WIDTH-1:0]   opa_mag, opb_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic               div_qbit;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign issue = start & (op != MD_NONE) & ~cancel;

  // DIV works on magnitudes; MULTU and DIVU use raw operands.
  assign opa_mag = ((op == MD_DIV) && opa[WIDTH-1]) ? -opa : opa;
  assign opb_mag = ((op == MD_DIV) && opb[WIDTH-1]) ? -opb : opb;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

  md_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .part_rem (acc_q[2*WIDTH-1:WIDTH-1]),
    .divisor  (b_q),
    .new_rem  (div_rem),
    .q_bit    (div_qbit)
  );

  // Final results from the accumulator: {HI, LO} = {product} or {remainder, quotient}.
  always_comb begin
    res_hi = acc_q[2*WIDTH-1:WIDTH];
    res_lo = acc_q[WIDTH-1:0];
    if ((op_q != MD_MULTU) && dz_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else if (op_q == MD_DIV) begin
      if (qneg_q) res_lo = -acc_q[WIDTH-1:0];
      if (rneg_q) res_hi = -acc_q[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          op_d    = op;
          a_d     = opa;
          b_d     = opb_mag;
          acc_d   = {{WIDTH{1'b0}}, opa_mag};
          cnt_d   = '0;
          qneg_d  = opa[WIDTH-1] ^ opb[WIDTH-1];
          rneg_d  = opa[WIDTH-1];
          dz_d    = (opb == '0);
          state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
          // A zero accumulator yields 0/0 for MULTU; division by zero is forced in FIN.
          if ((opb == '0) || ((op == MD_MULTU) && (opa == '0))) begin
            acc_d   = '0;
            state_d = FIN;
          end
`endif
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          if (op_q == MD_MULTU) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else begin
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_qbit};
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(ITER_LAST)) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!cancel) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy | issue;
  assign done  = (state_q == FIN) & ~cancel;
  assign hi_we = done;
  assign lo_we = done;
  // Results are visible during the FIN cycle and held afterwards.
  assign hi_out = done ? res_hi : hi_q;
  assign lo_out = done ? res_lo : lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        busy, stall, done, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(32), .ITER(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .opa    (opa),
    .opb    (opb),
    .cancel (cancel),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          early;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge; return at the negedge where done is seen (or timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic issue_stall, output logic we_ok,
                        output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    #1 issue_stall = stall;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    #1;
    we_ok = hi_we & lo_we;
    h = hi_out;
    l = lo_out;
  endtask

  initial begin
    int          lat, exp_lat;
    logic        st, we;
    logic [31:0] h, l, ph, pl;
    bit          seen;

    vecs[0]  = '{"multu_max",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{"div_m7_2",    MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[2]  = '{"divu_100_7",  MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[3]  = '{"div_ovf",     MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{"divu_5_0",    MD_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{"multu_x0",    MD_MULTU, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b1};
    vecs[6]  = '{"div_7_m2",    MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{"div_m8_0",    MD_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{"multu_2p32",  MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[9]  = '{"divu_max_1",  MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{"multu_0x",    MD_MULTU, 32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b1};
    vecs[11] = '{"multu_shift", MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = MD_NONE; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_we", {hi_we, lo_we}, 0);
    check("reset_hi", hi_out, 0);
    check("reset_lo", lo_out, 0);
    check("reset_stall", stall, 0);

    // start with op=0 is ignored
    @(negedge clk);
    start = 1'b1; op = MD_NONE; opa = 32'd3; opb = 32'd4;
    #1 check("op0_stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    check("op0_busy", busy, 0);

    for (int i = 0; i < 12; i++) begin
      exp_lat = (EarlyEn && vecs[i].early) ? 1 : 33;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, st, we, h, l);
      check({vecs[i].name, "_stall"}, st, 1);
      check({vecs[i].name, "_lat"}, lat, exp_lat);
      check({vecs[i].name, "_we"}, we, 1);
      check({vecs[i].name, "_hi"}, h, vecs[i].hi);
      check({vecs[i].name, "_lo"}, l, vecs[i].lo);
      @(negedge clk);
      #1;
      check({vecs[i].name, "_pulse"}, {done, busy}, 0);
      check({vecs[i].name, "_hold"}, {hi_out, lo_out}, {vecs[i].hi, vecs[i].lo});
    end

    // cancel at counter 10: no write, idle next cycle, outputs unchanged
    ph = hi_out; pl = lo_out;
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; opa = 32'd7; opb = 32'd9;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1 check("cancel_calc_done", done, 0);
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel_busy", busy, 0);
    seen = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("cancel_no_done", seen, 0);
    check("cancel_outputs", {hi_out, lo_out}, {ph, pl});
    run_op(MD_MULTU, 32'd3, 32'd4, lat, st, we, h, l);
    check("after_cancel_lo", l, 12);
    check("after_cancel_hi", h, 0);

    // cancel during FIN: no write pulse, outputs keep previous result
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    repeat (32) @(negedge clk);
    check("fin_reached", busy, 1);
    cancel = 1'b1;
    #1;
    check("fin_cancel_done", {done, hi_we, lo_we}, 0);
    check("fin_cancel_out", {hi_out, lo_out}, {32'd0, 32'd12});
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("fin_cancel_busy", busy, 0);
    check("fin_cancel_hold", {hi_out, lo_out}, {32'd0, 32'd12});

    // start together with cancel issues nothing
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = MD_MULTU; opa = 32'd2; opb = 32'd2;
    #1 check("start_cancel_stall", stall, 0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = MD_NONE;
    #1 check("start_cancel_busy", busy, 0);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; opa = 32'd3; opb = 32'd5;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    repeat (3) @(negedge clk);
    start = 1'b1; op = MD_DIVU; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    lat = 5;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    #1;
    check("busy_start_lat", lat, 33);
    check("busy_start_lo", lo_out, 15);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("busy_start_no_second", seen, 0);

    // synchronous reset mid-CALC clears everything
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", {busy, done}, 0);
    check("rst_mid_out", {hi_out, lo_out}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the HI/LO datapath; executes MULTU, DIV, DIVU issued by decode.
- Accepts the decoder's 2-bit muxfour encoding, iterates radix-2 for 32 cycles, then writes HI and LO together.
- Drives a stall to hold the pipeline while an operation is in flight.
- Sits beside the ALU and feeds the HI/LO registers; mfhi/mflo read those registers after completion.

Parameters:
- WIDTH, 32, operand width; result pair is 2*WIDTH.
- ITER, 32, iteration cycles; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue strobe; sampled only in IDLE.
- op  in  2  0=none, 1=MULTU, 2=DIV, 3=DIVU.
- opa  in  32  rs operand / dividend.
- opb  in  32  rt operand / divisor.
- cancel  in  1  exception flush; aborts the in-flight operation.
- busy  out  1  high whenever state != IDLE.
- stall  out  1  combinational: busy | (start & op!=0 & ~cancel).
- done  out  1  one-cycle completion pulse.
- hi_we  out  1  HI write enable; equals done.
- lo_we  out  1  LO write enable; equals done.
- hi_out  out  32  product[63:32] / remainder.
- lo_out  out  32  product[31:0] / quotient.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE; busy=done=hi_we=lo_we=0; hi_out=lo_out=0; counter=0.
  - rst overrides every other input.
- States: IDLE -> CALC -> FIN -> IDLE.
- IDLE:
  - On start & op!=0 & ~cancel, latch op, opa, opb; go to CALC at the next edge with counter=0.
  - start with op=0 is ignored.
- CALC, one step per cycle, counter 0..31:
  - MULTU: shift-add on a 64-bit accumulator with unsigned operands.
  - DIV: restoring division on |opa| and |opb|; record qneg = opa[31]^opb[31] and rneg = opa[31].
  - DIVU: restoring division on raw operands.
  - When counter==31, go to FIN.
- FIN (one cycle):
  - done=hi_we=lo_we=1; hi_out/lo_out hold the final results.
  - DIV applies sign fix: quotient negated if qneg, remainder negated if rneg.
  - Next state is IDLE.
- Latency: start sampled at edge T gives done high in the cycle after edge T+32 (33 cycles).
- busy is high from T+1 through the FIN cycle.
- hi_out/lo_out hold their last values after FIN until the next FIN.
- start while busy is ignored. Decode must not issue during stall, and the block does not queue.
- cancel:
  - In CALC or FIN: go to IDLE at the next edge, no write pulse, outputs unchanged.
  - With start in the same cycle: cancel wins and nothing is issued.
- Divide by zero (opb==0, DIV or DIVU): results are forced to lo_out=32'hFFFFFFFF, hi_out=opa (raw, no sign fix); no exception raised.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo_out=0x80000000, hi_out=0 (the natural magnitude result; no trap).
- Arithmetic: all internal paths are WIDTH+1 bits for the subtract; 64-bit accumulator.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, on issue with opb==0 (any op) or opa==0 (MULTU), go directly to FIN.
  - FIN produces the results as defined above: MULTU gives 0/0; division by zero gives the forced results.
  - done appears in the cycle after edge T (latency 1).
- Undefined: all operations take the full 33 cycles; results are identical.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings MD_NONE=2'd0, MD_MULTU=2'd1, MD_DIV=2'd2, MD_DIVU=2'd3, matching the decoder's muxfour.
  - state encodings IDLE/CALC/FIN.
  - ITER_LAST=5'd31.
- One sub-module: md_divstep.
  - Combinational single restoring-division step: partial remainder and divisor in; new remainder and quotient bit out.
  - Instantiated once and reused each CALC cycle.

Test Plan:
- MULTU opa=0xFFFFFFFF opb=0xFFFFFFFF -> hi_out=0xFFFFFFFE, lo_out=0x00000001; done exactly 33 cycles after start; stall high from the issue cycle.
- DIV opa=0xFFFFFFF9 (-7) opb=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- DIVU opa=100 opb=7 -> lo_out=0x0000000E, hi_out=0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- DIVU opa=5 opb=0 -> lo_out=0xFFFFFFFF, hi_out=5; latency 33 without MULDIV_EARLY_OUT_EN, 1 with it.
- Abort cases:
  - cancel at CALC counter=10 -> no done/we pulse, busy=0 next cycle; a new MULTU 3*4 then yields lo_out=12.
  - rst mid-CALC -> all outputs 0 next cycle.
  - start during busy -> ignored.
